// File: rtl/cla_sub_serial.sv
// cla_sub_serial
// Slice-serial subtractor: diff = a - b - b_in (mod 2^WIDTH), computed as
// a + ~b + ~b_in, one 4-bit carry-lookahead slice per clock, LSB slice first.
// The inter-slice carry lives in a register.
//
// Parameters:
//   WIDTH     operand width, multiple of 4, >= 4 (N = WIDTH/4 slices)
//
// Ports:
//   clk_i     rising-edge clock
//   rst_n_i   synchronous active-low reset
//   start_i   request, accepted only in IDLE
//   a_i       minuend, sampled on the accepting edge
//   b_i       subtrahend, sampled on the accepting edge
//   b_in_i    borrow in, sampled on the accepting edge
//   busy_o    high while computing slices
//   done_o    one-cycle pulse, result valid
//   diff_o    difference (holds until the next accepted start)
//   b_out_o   borrow out, 1 iff unsigned a < b + b_in
//   ovf_o     signed overflow
//
// Build option:
//   CLA_SUB_OVF_EN  when defined, ovf_o reports signed overflow of the
//                   latched operands; otherwise ovf_o is tied to 0.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start_i; result outputs hold
// RUN   | one slice per edge, slice index 0 .. N-1
// DONE  | done_o high for one cycle, back to IDLE next edge

module cla_sub_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             b_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             b_out_o,
  output logic             ovf_o
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Current slice: b is inverted so the slice is a plain lookahead adder.
  logic [3:0] sl_a, sl_bn, g, p, sum;
  logic [4:0] c;

  always_comb begin
    sl_a  = a_q[4*idx_q +: 4];
    sl_bn = ~b_q[4*idx_q +: 4];
    g     = sl_a & sl_bn;
    p     = sl_a ^ sl_bn;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum   = p ^ c[3:0];
  end

  logic last_slice;
  assign last_slice = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = ~b_in_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[4*idx_q +: 4] = sum;
        carry_d              = c[4];
        if (last_slice) begin
          b_out_d = ~c[4];
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CLA_SUB_OVF_EN
  // Operand signs differ and the result sign differs from the minuend.
  // sum[3] is the result MSB when the final slice is being computed.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last_slice) begin
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[3] != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign diff_o  = diff_q;
  assign b_out_o = b_out_q;

endmodule

// File: tb/tb_cla_sub_serial.sv
// Testbench for cla_sub_serial at WIDTH = 4, 16 and 32 sharing one stimulus.
module tb_cla_sub_serial;

`ifdef CLA_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam int NDUT = 3;
  int wid [NDUT] = '{4, 16, 32};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in, b_in_v;
  logic        bin;

  logic        busy4, done4, bout4, ovf4;
  logic [3:0]  diff4;
  logic        busy16, done16, bout16, ovf16;
  logic [15:0] diff16;
  logic        busy32, done32, bout32, ovf32;
  logic [31:0] diff32;

  logic        busy_v [NDUT];
  logic        done_v [NDUT];
  logic        bout_v [NDUT];
  logic        ovf_v  [NDUT];
  logic [31:0] diff_v [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_sub_serial #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .a_i(a_in[3:0]), .b_i(b_in_v[3:0]), .b_in_i(bin),
    .busy_o(busy4), .done_o(done4), .diff_o(diff4), .b_out_o(bout4), .ovf_o(ovf4));

  cla_sub_serial #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .a_i(a_in[15:0]), .b_i(b_in_v[15:0]), .b_in_i(bin),
    .busy_o(busy16), .done_o(done16), .diff_o(diff16), .b_out_o(bout16), .ovf_o(ovf16));

  cla_sub_serial #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .a_i(a_in), .b_i(b_in_v), .b_in_i(bin),
    .busy_o(busy32), .done_o(done32), .diff_o(diff32), .b_out_o(bout32), .ovf_o(ovf32));

  assign busy_v[0] = busy4;  assign done_v[0] = done4;
  assign bout_v[0] = bout4;  assign ovf_v[0]  = ovf4;
  assign diff_v[0] = {28'd0, diff4};
  assign busy_v[1] = busy16; assign done_v[1] = done16;
  assign bout_v[1] = bout16; assign ovf_v[1]  = ovf16;
  assign diff_v[1] = {16'd0, diff16};
  assign busy_v[2] = busy32; assign done_v[2] = done32;
  assign bout_v[2] = bout32; assign ovf_v[2]  = ovf32;
  assign diff_v[2] = diff32;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;   // signed overflow condition; reported only with the option
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic bi, output logic [31:0] d,
                                output logic bo, output logic ov);
    longint mask, half, ua, ub, sa, sb, r, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    r    = ua - ub - longint'(bi);
    d    = 32'(r & mask);
    bo   = (ua < ub + longint'(bi));
    sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
    sr   = sa - sb - longint'(bi);
    ov   = OVF_EN && ((sr < -half) || (sr > half - 1));
  endfunction

  task automatic run16(input vec_t v, input string tag);
    int busy_cnt;
    a_in   = {16'd0, v.a};
    b_in_v = {16'd0, v.b};
    bin    = v.bin;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    a_in   = $urandom;
    b_in_v = $urandom;
    bin    = 1'($urandom_range(0, 1));
    busy_cnt = busy16 ? 1 : 0;
    check({tag, " done@k"}, {31'd0, done16}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("%s done@k+%0d", tag, c), {31'd0, done16}, {31'd0, (c == 4)});
      if (busy16) busy_cnt++;
    end
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, " diff"}, {16'd0, diff16}, {16'd0, v.diff});
    check({tag, " b_out"}, {31'd0, bout16}, {31'd0, v.bout});
    check({tag, " ovf"}, {31'd0, ovf16}, {31'd0, v.ovf & OVF_EN});
    tick();
    check({tag, " done@k+5"}, {31'd0, done16}, 32'd0);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  vec_t vecs [8];

  initial begin
    logic [31:0] ed [NDUT];
    logic        eb [NDUT];
    logic        eo [NDUT];
    int          nsl;

    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in_v = '0;
    bin    = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("w%0d reset busy", wid[i]), {31'd0, busy_v[i]}, 32'd0);
      check($sformatf("w%0d reset done", wid[i]), {31'd0, done_v[i]}, 32'd0);
      check($sformatf("w%0d reset diff", wid[i]), diff_v[i], 32'd0);
      check($sformatf("w%0d reset b_out", wid[i]), {31'd0, bout_v[i]}, 32'd0);
      check($sformatf("w%0d reset ovf", wid[i]), {31'd0, ovf_v[i]}, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run16(vecs[i], $sformatf("vec%0d", i));
      idle(6);
    end

    // start pulses while busy/done are ignored; accepted again at k+6
    a_in = 32'h00F0; b_in_v = 32'h000F; bin = 1'b0; start = 1'b1;
    tick();                                   // edge k
    a_in = 32'hFFFF; b_in_v = 32'h0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("ign busy@k+%0d", c), {31'd0, busy16}, 32'd1);
    end
    tick();                                   // k+4
    check("ign done@k+4", {31'd0, done16}, 32'd1);
    check("ign diff@k+4", {16'd0, diff16}, 32'h00E1);
    tick();                                   // k+5: DONE -> IDLE, start ignored
    check("ign busy@k+5", {31'd0, busy16}, 32'd0);
    check("ign done@k+5", {31'd0, done16}, 32'd0);
    tick();                                   // k+6: accepted
    check("ign busy@k+6", {31'd0, busy16}, 32'd1);
    start = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      tick();
      check($sformatf("ign2 done@k+%0d", c), {31'd0, done16}, {31'd0, (c == 10)});
    end
    check("ign2 diff", {16'd0, diff16}, 32'hFFFE);
    check("ign2 b_out", {31'd0, bout16}, 32'd0);
    idle(12);

    // reset in the middle of an operation
    a_in = 32'h0000_1234; b_in_v = 32'h0000_0034; bin = 1'b0; start = 1'b1;
    tick();                                   // k
    start = 1'b0;
    tick();                                   // k+1
    rst_n = 1'b0;
    tick();                                   // k+2
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("w%0d midrst busy", wid[i]), {31'd0, busy_v[i]}, 32'd0);
      check($sformatf("w%0d midrst done", wid[i]), {31'd0, done_v[i]}, 32'd0);
      check($sformatf("w%0d midrst diff", wid[i]), diff_v[i], 32'd0);
      check($sformatf("w%0d midrst b_out", wid[i]), {31'd0, bout_v[i]}, 32'd0);
      check($sformatf("w%0d midrst ovf", wid[i]), {31'd0, ovf_v[i]}, 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 3; c <= 5; c++) begin
      tick();
      check($sformatf("midrst no done@k+%0d", c), {31'd0, done16}, 32'd0);
      check($sformatf("midrst no busy@k+%0d", c), {31'd0, busy16}, 32'd0);
    end
    run16(vecs[3], "after rst");
    idle(12);

    // random regression across all widths
    for (int op = 0; op < 3000; op++) begin
      a_in   = $urandom;
      b_in_v = $urandom;
      bin    = 1'($urandom_range(0, 1));
      if (op % 16 == 1) a_in = 32'h0;
      if (op % 16 == 2) b_in_v = 32'hFFFF_FFFF;
      if (op % 16 == 3) b_in_v = a_in;
      for (int i = 0; i < NDUT; i++) model(wid[i], a_in, b_in_v, bin, ed[i], eb[i], eo[i]);
      start = 1'b1;
      tick();
      start  = 1'b0;
      a_in   = $urandom;
      b_in_v = $urandom;
      bin    = 1'($urandom_range(0, 1));
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("r%0d w%0d busy@k", op, wid[i]), {31'd0, busy_v[i]}, 32'd1);
        check($sformatf("r%0d w%0d done@k", op, wid[i]), {31'd0, done_v[i]}, 32'd0);
      end
      for (int c = 1; c <= 9; c++) begin
        tick();
        for (int i = 0; i < NDUT; i++) begin
          nsl = wid[i] / 4;
          check($sformatf("r%0d w%0d done@k+%0d", op, wid[i], c),
                {31'd0, done_v[i]}, {31'd0, (c == nsl)});
          check($sformatf("r%0d w%0d busy@k+%0d", op, wid[i], c),
                {31'd0, busy_v[i]}, {31'd0, (c < nsl)});
          if (c >= nsl) begin
            check($sformatf("r%0d w%0d diff@k+%0d", op, wid[i], c), diff_v[i], ed[i]);
            check($sformatf("r%0d w%0d b_out@k+%0d", op, wid[i], c),
                  {31'd0, bout_v[i]}, {31'd0, eb[i]});
            check($sformatf("r%0d w%0d ovf@k+%0d", op, wid[i], c),
                  {31'd0, ovf_v[i]}, {31'd0, eo[i]});
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
